// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core front end:
//   PC_W          - program counter / address width
//   PC_RESET_DEF  - default PC loaded on reset
//   fetch_state_e - instruction-fetch FSM states
//   OP_*          - opcode constants used by the decoder on instr[31:26]
//   pc_plus4      - sequential next-PC helper (wraps modulo 2^PC_W)
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] PC_RESET_DEF = 32'h0000_0000;

  // FETCH: nothing outstanding, WAIT: one granted request outstanding,
  // DROP: outstanding request whose response is to be thrown away.
  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for a fetched instruction and its PC+4, used
// when the IF/ID register is stalled at the moment a response arrives.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_load              capture i_instr/i_pc4 and mark full
//   i_unload            entry has been moved out; mark empty
//   i_clear             discard the entry (redirect); wins over load
//   i_instr, i_pc4      data to capture
//   o_full              entry valid
//   o_instr, o_pc4      held data
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc4,
  output logic            o_full,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc4
);

  logic            r_full;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc4   <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, runs the instruction-memory
// request/grant/response handshake (at most one request outstanding), and
// fills the IF/ID register with {instr, pc+4}. Downstream redirects reload
// the PC and squash anything in flight; decode back-pressure is absorbed by
// a one-entry skid buffer.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imem_req/imem_addr              fetch request (combinational)
//   imem_gnt                        request accepted this cycle
//   imem_rvalid/imem_rdata          response
//   redirect_valid/redirect_pc      taken jump/branch, highest priority
//   id_ready                        decode consumes IF/ID this cycle
//   if_id_valid/instr/pc4           IF/ID register outputs
// ---------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_ifid_valid;
  logic [31:0]     r_ifid_instr;
  logic [PC_W-1:0] r_ifid_pc4;

  logic            w_skid_full;
  logic [31:0]     w_skid_instr;
  logic [PC_W-1:0] w_skid_pc4;
  logic            w_resp;
  logic            w_ifid_open;
  logic            w_req;
  logic            w_grant;
  logic            w_skid_load;
  logic            w_skid_unload;
  logic [PC_W-1:0] w_redirect_pc;

  // Response for the live (non-dropped) request.
  assign w_resp      = (r_state == FS_WAIT) && imem_rvalid;
  // IF/ID may take a new word: empty, or its current word leaves this cycle.
  assign w_ifid_open = !r_ifid_valid || id_ready;

  // A follow-on request in WAIT is only safe when the arriving word goes
  // straight to IF/ID; otherwise it would fill the skid and leave the next
  // response with nowhere to land.
  assign w_req = !reset && !w_skid_full &&
                 ((r_state == FS_FETCH) || (w_resp && w_ifid_open));
  assign w_grant = w_req && imem_gnt;

  assign w_skid_load   = w_resp && !w_ifid_open && !redirect_valid;
  assign w_skid_unload = w_skid_full && w_ifid_open;

  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  // PC / FSM. r_pc always holds the next address to request; it advances on
  // grant, so while in WAIT it equals (outstanding address + 4).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FS_FETCH;
      r_pc    <= PC_RESET;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_pc;
      // Anything granted now, or still waiting for its response, is stale.
      if (w_grant || ((r_state != FS_FETCH) && !imem_rvalid))
        r_state <= FS_DROP;
      else
        r_state <= FS_FETCH;
    end else if (w_grant) begin
      r_pc    <= pc_plus4(r_pc);
      r_state <= FS_WAIT;
    end else if ((r_state != FS_FETCH) && imem_rvalid) begin
      // WAIT without a follow-on grant, or DROP absorbing its response.
      r_state <= FS_FETCH;
    end
  end

  // IF/ID register: skid entry is older than any arriving response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (redirect_valid) begin
      r_ifid_valid <= 1'b0;
    end else if (w_ifid_open) begin
      if (w_skid_full) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= w_skid_instr;
        r_ifid_pc4   <= w_skid_pc4;
      end else if (w_resp) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= imem_rdata;
        r_ifid_pc4   <= r_pc;
      end else begin
        r_ifid_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (redirect_valid),
    .i_instr  (imem_rdata),
    .i_pc4    (r_pc),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_pc4    (w_skid_pc4)
  );

  assign if_id_valid = r_ifid_valid;
  assign if_id_instr = r_ifid_instr;
  assign if_id_pc4   = r_ifid_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Randomised memory/decode/redirect stimulus around fetch_unit. Expected
// IF/ID contents follow program order: start at PC_RESET, +4 per word,
// restart at the aligned target on redirect, restart at PC_RESET on reset.
// Granted requests push the expected word into a queue; an independent
// monitor compares IF/ID against the queue head and pops on consumption.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  fetch_unit #(.PC_RESET(PC_RST)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          consumed = 0;

  // stimulus knobs
  int          gnt_pct, rdy_pct, redir_pml, dly_min, dly_max;
  bit          redir_now, redir_on_rv;
  logic [31:0] redir_tgt;

  // memory model and program-order reference
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] next_fetch;

  // per-cycle samples taken at the falling edge
  bit          s_valid, s_req, s_gnt, s_redir;
  logic [31:0] s_addr, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle; entered and left at rising edge + 1.
  task automatic cycle();
    logic [31:0] ra;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    id_ready       = ($urandom_range(99) < rdy_pct);
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (redir_now || (redir_on_rv && imem_rvalid)) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_now      = 1'b0;
      redir_on_rv    = 1'b0;
    end else if ($urandom_range(999) < redir_pml) begin
      redirect_valid = 1'b1;
      ra = $urandom_range(32'h0000_0FFF);
      redirect_pc = ($urandom_range(3) == 0) ? $urandom : ra;
    end
    @(negedge clk);
    s_valid = if_id_valid;
    s_pc4   = if_id_pc4;
    s_req   = imem_req;
    s_gnt   = imem_gnt;
    s_addr  = imem_addr;
    s_redir = redirect_valid;
    if (imem_req && imem_gnt) begin
      check("single_outstanding", 32'(pend), 32'd0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = $urandom_range(dly_max, dly_min);
    end
    if (redirect_valid) begin
      exp_q.delete();
      next_fetch = {redirect_pc[31:2], 2'b00};
    end else if (imem_req && imem_gnt) begin
      check("req_addr", imem_addr, next_fetch);
      exp_q.push_back('{instr: mem_word(next_fetch), pc4: next_fetch + 32'd4});
      next_fetch = next_fetch + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend        = 1'b0;
    next_fetch  = PC_RST;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    check({tag, "_instr"}, if_id_instr, 32'd0);
    check({tag, "_pc4"},   if_id_pc4, 32'd0);
  endtask

  // Monitor: IF/ID must always show the oldest unconsumed word.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && if_id_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ifid_unexpected: got instr %h pc4 %h, expected no valid word", if_id_instr, if_id_pc4);
      end else begin
        check("ifid_instr", if_id_instr, exp_q[0].instr);
        check("ifid_pc4", if_id_pc4, exp_q[0].pc4);
        if (id_ready) begin
          exp_q.delete(0);
          consumed++;
        end
      end
    end
  end

  initial begin
    int  lat, cnt;
    bit  found;
    reset = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    redir_now = 0; redir_on_rv = 0; redir_tgt = 0;
    gnt_pct = 100; rdy_pct = 100; redir_pml = 0; dly_min = 0; dly_max = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Zero-wait start-up and sustained streaming
    lat = -1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (s_valid && lat < 0) lat = k;
    end
    check("startup_edges", lat, 32'd2);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_valid) cnt++;
    end
    check("stream_rate", cnt, 32'd10);

    // Decode stall for 3 cycles
    rdy_pct = 0;
    cycle(); cycle(); cycle();
    check("stall_req_low", 32'(s_req), 32'd0);
    check("stall_valid_held", 32'(s_valid), 32'd1);
    rdy_pct = 100;
    repeat (10) cycle();

    // Redirect to 0x100 with the outstanding response 3 cycles late
    dly_min = 3; dly_max = 3;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (pend && pend_cnt == 3) found = 1;
    end
    check("redir100_outstanding_seen", 32'(found), 32'd1);
    redir_tgt = 32'h0000_0100; redir_now = 1;
    cycle();
    dly_min = 0; dly_max = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_valid) found = 1;
    end
    check("redir100_first_seen", 32'(found), 32'd1);
    check("redir100_first_pc4", s_pc4, 32'h0000_0104);
    repeat (5) cycle();

    // Redirect coinciding with rvalid, unaligned target
    dly_min = 1; dly_max = 1;
    redir_tgt = 32'h0000_0203; redir_on_rv = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_redir) found = 1;
    end
    check("redir203_fired", 32'(found), 32'd1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_req && s_gnt) found = 1;
    end
    check("redir203_req_seen", 32'(found), 32'd1);
    check("redir203_req_addr", s_addr, 32'h0000_0200);
    dly_min = 0; dly_max = 0;
    repeat (6) cycle();

    // Redirect to the top word: pc+4 wraps to 0
    redir_tgt = 32'hFFFF_FFFC; redir_now = 1;
    cycle();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_valid) found = 1;
    end
    check("wrap_first_seen", 32'(found), 32'd1);
    check("wrap_pc4", s_pc4, 32'd0);
    repeat (6) cycle();

    // Random traffic
    gnt_pct = 70; rdy_pct = 70; redir_pml = 20; dly_min = 0; dly_max = 3;
    repeat (1500) cycle();
    redir_pml = 0;

    // Async reset with the skid full
    gnt_pct = 100; rdy_pct = 100; dly_min = 0; dly_max = 0;
    repeat (5) cycle();
    rdy_pct = 0;
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_skid");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    rdy_pct = 100;
    cycle();
    check("post_reset_req", 32'(s_req && s_gnt), 32'd1);
    check("post_reset_addr", s_addr, PC_RST);
    repeat (10) cycle();

    // Async reset while a slow response is outstanding
    dly_min = 3; dly_max = 3;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (pend) found = 1;
    end
    check("wait_outstanding_seen", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_wait");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    dly_min = 0; dly_max = 2; gnt_pct = 80; rdy_pct = 80;
    repeat (60) cycle();

    check("words_consumed_min", 32'(consumed >= 150), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
